// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and the fetch FSM state type for the IF stage.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;
  localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// IF-stage bus: imem port, redirect/stall controls and IF/ID outputs; master is the fetch stage.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               exc_req;
  logic [ADDR_W-1:0]  pc_out;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc_plus2;
  logic               ifid_valid;
  logic               fetch_fault;

  modport master (
    output imem_addr, pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_fault,
    input  imem_instr, stall, branch_taken, branch_target, exc_req
  );

  modport slave (
    input  imem_addr, pc_out, ifid_instr, ifid_pc_plus2, ifid_valid, fetch_fault,
    output imem_instr, stall, branch_taken, branch_target, exc_req
  );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush loads a bubble and beats hold; hold beats load.
// With no control asserted the register keeps its contents.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               hold,
  input  logic               load,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [ADDR_W-1:0]  next_pc_plus2,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr    <= NOP_INSTR;
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (!hold && load) begin
      instr    <= next_instr;
      pc_plus2 <= next_pc_plus2;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses imem combinationally from the PC register, and
// captures instr/PC+2 into IF/ID one edge later; parks in FAULT on a bad fetch address.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                IMEM_BYTES = 100,
  parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 16'h0030
) (
  input  logic            clk,
  input  logic            rst,
  fetch_stage_if.master   bus
);

  localparam logic [31:0] LAST_FETCH = 32'(IMEM_BYTES - 2);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic              fetch_ok;
  logic              flush, hold, load;

  assign pc_plus2 = pc_q + PC_STEP;
  assign fetch_ok = ({{(32-ADDR_W){1'b0}}, pc_q} <= LAST_FETCH) && !pc_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Redirects outrank FAULT and stall so a stalled ID instruction is squashed.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    flush   = 1'b0;
    hold    = 1'b0;
    load    = 1'b0;
    if (bus.exc_req) begin
      pc_d    = EXC_VECTOR;
      state_d = RUN;
      flush   = 1'b1;
    end else if (bus.branch_taken) begin
      pc_d    = bus.branch_target;
      state_d = bus.branch_target[0] ? FAULT : RUN;
      flush   = 1'b1;
    end else if (state_q == FAULT) begin
      flush   = 1'b1;
    end else if (bus.stall) begin
      hold    = 1'b1;
    end else if (fetch_ok) begin
      pc_d    = pc_plus2;
      load    = 1'b1;
    end else begin
      state_d = FAULT;
      flush   = 1'b1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .hold          (hold),
    .load          (load),
    .next_instr    (bus.imem_instr),
    .next_pc_plus2 (pc_plus2),
    .instr         (bus.ifid_instr),
    .pc_plus2      (bus.ifid_pc_plus2),
    .valid         (bus.ifid_valid)
  );

  assign bus.imem_addr   = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.fetch_fault = (state_q == FAULT);

endmodule
